// File: rtl/ring_interlock_pkg.sv
// Shared types and elaboration-time helpers for the ring interlock controller.
package ring_interlock_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StActive,
    StRelease,
    StFault
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ring_rr_pick.sv
// Combinational round-robin picker: first requesting channel at or after ptr, cyclically.
module ring_rr_pick
  import ring_interlock_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]          req,
  input  logic [clog2(N)-1:0]   ptr,
  output logic                  valid,
  output logic [clog2(N)-1:0]   idx
);

  localparam int unsigned IdxW  = clog2(N);
  localparam int unsigned IdxW1 = IdxW + 1;
  localparam logic [IdxW:0] NumCh = IdxW1'(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IdxW-1:0] off;
  logic [IdxW:0]  sum;

  always_comb begin
    // Rotating the doubled vector puts channel ptr at bit 0.
    dbl   = {req, req} >> ptr;
    rot   = dbl[N-1:0];
    valid = |req;
    off   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = IdxW'(i);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= NumCh) sum = sum - NumCh;
    idx = sum[IdxW-1:0];
  end

endmodule

// File: rtl/ring_interlock_ctrl.sv
// Ring interlock controller: one round-robin grant at a time, supervised through
// arm/hold/release with timeouts and a latched fault cleared only explicitly.
module ring_interlock_ctrl
  import ring_interlock_pkg::*;
#(
  parameter int unsigned N        = 8,
  parameter int unsigned TIMEOUT  = 100,
  parameter int unsigned MIN_HOLD = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        i_req,
  input  logic [N-1:0]        i_fb,
  input  logic                i_clr_fault,
  output logic [N-1:0]        o_grant,
  output logic                o_busy,
  output logic                o_fault,
  output logic [clog2(N)-1:0] o_fault_ch
);

  localparam int unsigned IdxW = clog2(N);
  localparam int unsigned CntW = clog2(max_u(TIMEOUT, MIN_HOLD) + 1);
  localparam logic [CntW-1:0] CntTimeout = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] CntHold    = CntW'(MIN_HOLD - 1);
  localparam logic [CntW-1:0] CntMax     = '1;
  localparam logic [IdxW-1:0] LastIdx    = IdxW'(N - 1);

  state_e          state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] sel_q, sel_d;
  logic [IdxW-1:0] fault_ch_q, fault_ch_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    grant_q, grant_d;

  logic            pick_valid;
  logic [IdxW-1:0] pick_idx;
  logic [N-1:0]    sel_oh;
  logic [N-1:0]    foreign;
  logic [IdxW-1:0] foreign_idx;
  logic            go_fault;
  logic [IdxW-1:0] blame;

  ring_rr_pick #(
    .N(N)
  ) u_pick (
    .req  (i_req),
    .ptr  (ptr_q),
    .valid(pick_valid),
    .idx  (pick_idx)
  );

  // Any energised actuator other than the selected one is foreign; in IDLE all are.
  always_comb begin
    sel_oh      = N'(1) << sel_q;
    foreign     = (state_q == StIdle) ? i_fb : (i_fb & ~sel_oh);
    foreign_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (foreign[k]) foreign_idx = IdxW'(k);
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    grant_d    = grant_q;
    fault_ch_d = fault_ch_q;
    cnt_d      = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
    go_fault   = 1'b0;
    blame      = sel_q;

    if (state_q != StFault && |foreign) begin
      go_fault = 1'b1;
      blame    = foreign_idx;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d = '0;
          if (pick_valid) begin
            state_d = StArm;
            sel_d   = pick_idx;
            grant_d = N'(1) << pick_idx;
          end
        end
        StArm: begin
          if (i_fb[sel_q]) begin
            state_d = StActive;
            cnt_d   = '0;
          end else if (cnt_q == CntTimeout) begin
            go_fault = 1'b1;
          end
        end
        StActive: begin
          // Losing feedback while granted outranks a release request.
          if (!i_fb[sel_q]) begin
            go_fault = 1'b1;
          end else if (!i_req[sel_q] && cnt_q >= CntHold) begin
            state_d = StRelease;
            grant_d = '0;
            cnt_d   = '0;
          end
        end
        StRelease: begin
          if (!i_fb[sel_q]) begin
            state_d = StIdle;
            cnt_d   = '0;
            ptr_d   = (sel_q == LastIdx) ? '0 : sel_q + IdxW'(1);
          end else if (cnt_q == CntTimeout) begin
            go_fault = 1'b1;
          end
        end
        StFault: begin
          cnt_d   = '0;
          grant_d = '0;
          if (i_clr_fault && i_fb == '0) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end

    if (go_fault) begin
      state_d    = StFault;
      grant_d    = '0;
      cnt_d      = '0;
      fault_ch_d = blame;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      sel_q      <= '0;
      fault_ch_q <= '0;
      cnt_q      <= '0;
      grant_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      fault_ch_q <= fault_ch_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
    end
  end

  assign o_grant    = grant_q;
  assign o_busy     = (state_q == StArm) || (state_q == StActive) || (state_q == StRelease);
  assign o_fault    = (state_q == StFault);
  assign o_fault_ch = fault_ch_q;

endmodule

// File: tb/tb_ring_interlock_ctrl.sv
// Randomised and directed bench for ring_interlock_ctrl against a behavioural model.
module tb_ring_interlock_ctrl;

  localparam int unsigned N        = 8;
  localparam int unsigned TIMEOUT  = 10;
  localparam int unsigned MIN_HOLD = 4;
  localparam int PhIdle = 0, PhArm = 1, PhActive = 2, PhRelease = 3, PhFault = 4;

  logic       clk = 1'b0;
  logic       rst, clr;
  logic [7:0] req, fb;
  logic [7:0] grant;
  logic       busy, fault;
  logic [2:0] fault_ch;

  logic       rst3, clr3;
  logic [2:0] req3, fb3, grant3;
  logic       busy3, fault3;
  logic [1:0] fault_ch3;

  int n_checks = 0;
  int n_pass   = 0;

  int m_phase, m_ptr, m_sel, m_age, m_fch;

  always #5 clk = ~clk;

  ring_interlock_ctrl #(
    .N(N), .TIMEOUT(TIMEOUT), .MIN_HOLD(MIN_HOLD)
  ) dut (
    .clk(clk), .rst(rst), .i_req(req), .i_fb(fb), .i_clr_fault(clr),
    .o_grant(grant), .o_busy(busy), .o_fault(fault), .o_fault_ch(fault_ch)
  );

  ring_interlock_ctrl #(
    .N(3), .TIMEOUT(10), .MIN_HOLD(4)
  ) dut3 (
    .clk(clk), .rst(rst3), .i_req(req3), .i_fb(fb3), .i_clr_fault(clr3),
    .o_grant(grant3), .o_busy(busy3), .o_fault(fault3), .o_fault_ch(fault_ch3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic int first_req_from(input int from, input logic [7:0] r);
    for (int o = 0; o < N; o++) begin
      if (r[(from + o) % N]) return (from + o) % N;
    end
    return -1;
  endfunction

  function automatic int lowest(input logic [7:0] v);
    for (int k = 0; k < N; k++) if (v[k]) return k;
    return -1;
  endfunction

  task automatic model_fault(input int ch);
    m_phase = PhFault;
    m_fch   = ch;
  endtask

  // Advances the model by one clock using the inputs about to be sampled.
  task automatic model_step();
    int f;
    if (rst) begin
      m_phase = PhIdle; m_ptr = 0; m_sel = 0; m_age = 0; m_fch = 0;
      return;
    end
    f = (m_phase == PhIdle) ? lowest(fb) : lowest(fb & ~(8'(1) << m_sel));
    if (m_phase != PhFault && f >= 0) begin
      model_fault(f);
      return;
    end
    case (m_phase)
      PhIdle: begin
        f = first_req_from(m_ptr, req);
        if (f >= 0) begin m_sel = f; m_phase = PhArm; m_age = 0; end
      end
      PhArm: begin
        if (fb[m_sel]) begin m_phase = PhActive; m_age = 0; end
        else if (m_age == TIMEOUT - 1) model_fault(m_sel);
        else m_age++;
      end
      PhActive: begin
        if (!fb[m_sel]) model_fault(m_sel);
        else if (!req[m_sel] && m_age >= MIN_HOLD - 1) begin m_phase = PhRelease; m_age = 0; end
        else m_age++;
      end
      PhRelease: begin
        if (!fb[m_sel]) begin m_phase = PhIdle; m_ptr = (m_sel + 1) % N; end
        else if (m_age == TIMEOUT - 1) model_fault(m_sel);
        else m_age++;
      end
      default: if (clr && fb == 8'h00) m_phase = PhIdle;
    endcase
  endtask

  task automatic tick();
    logic [7:0] exp_grant;
    model_step();
    @(posedge clk);
    #1;
    exp_grant = (m_phase == PhArm || m_phase == PhActive) ? (8'(1) << m_sel) : 8'h00;
    check_eq("grant", 32'(grant), 32'(exp_grant));
    check_eq("busy", 32'(busy), 32'(m_phase == PhArm || m_phase == PhActive || m_phase == PhRelease));
    check_eq("fault", 32'(fault), 32'(m_phase == PhFault));
    check_eq("fault_ch", 32'(fault_ch), 32'(m_fch));
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 8'h00; fb = 8'h00; clr = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Grant, hold and release one channel of the N=3 instance.
  task automatic serve3(input logic [2:0] r, input logic [2:0] exp_g, input string tag);
    req3 = r;
    tick();
    check_eq({tag, "_grant"}, 32'(grant3), 32'(exp_g));
    fb3  = grant3;
    req3 = 3'b000;
    repeat (5) tick();
    check_eq({tag, "_rel"}, 32'(grant3), 32'h0);
    fb3 = 3'b000;
    tick();
    check_eq({tag, "_idle"}, 32'(busy3), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] prev, follow, frozen;
    logic [7:0] gq[$];
    logic [7:0] rr_exp[4];
    int b;
    rr_exp = '{8'h01, 8'h80, 8'h01, 8'h80};
    rst3 = 1'b1; req3 = '0; fb3 = '0; clr3 = 1'b0;

    // Basic grant/hold.
    do_reset();
    check_eq("reset_grant", 32'(grant), 32'h0);
    check_eq("reset_fault", 32'(fault), 32'h0);
    req = 8'h04;
    tick();
    check_eq("basic_grant", 32'(grant), 32'h04);
    tick();
    fb = 8'h04;
    tick();
    req = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("basic_hold", 32'(grant), 32'h04);
      check_eq("basic_busy", 32'(busy), 32'h1);
    end
    tick();
    check_eq("basic_release", 32'(grant), 32'h00);
    check_eq("basic_rel_busy", 32'(busy), 32'h1);
    fb = 8'h00;
    tick();
    check_eq("basic_idle", 32'(busy), 32'h0);
    req = 8'hFF;
    tick();
    check_eq("basic_ptr3", 32'(grant), 32'h08);

    // Round-robin fairness.
    do_reset();
    req  = 8'h81;
    prev = 8'h00;
    for (int c = 0; c < 80 && gq.size() < 4; c++) begin
      tick();
      if (grant != 8'h00 && prev == 8'h00) gq.push_back(grant);
      prev = grant;
      fb   = grant;
      req  = 8'h81 & ~grant;
    end
    check_eq("rr_count", 32'(gq.size()), 32'd4);
    for (int i = 0; i < gq.size(); i++) check_eq("rr_seq", 32'(gq[i]), 32'(rr_exp[i]));

    // ARM timeout.
    do_reset();
    req = 8'h08;
    tick();
    check_eq("arm_grant", 32'(grant), 32'h08);
    for (int i = 0; i < 9; i++) begin
      tick();
      check_eq("arm_wait", 32'(fault), 32'h0);
    end
    tick();
    check_eq("arm_to_fault", 32'(fault), 32'h1);
    check_eq("arm_to_ch", 32'(fault_ch), 32'd3);
    check_eq("arm_to_grant", 32'(grant), 32'h0);
    req = 8'h00; clr = 1'b1;
    tick();
    check_eq("arm_clr", 32'(fault), 32'h0);
    clr = 1'b0;

    // Foreign feedback and clear.
    do_reset();
    req = 8'h02;
    tick();
    fb = 8'h02;
    tick();
    fb = 8'h22;
    tick();
    check_eq("foreign_fault", 32'(fault), 32'h1);
    check_eq("foreign_ch", 32'(fault_ch), 32'd5);
    check_eq("foreign_grant", 32'(grant), 32'h0);
    fb = 8'h20; clr = 1'b1;
    tick();
    check_eq("clr_ignored", 32'(fault), 32'h1);
    fb = 8'h00;
    tick();
    check_eq("clr_ok", 32'(fault), 32'h0);
    check_eq("clr_idle", 32'(busy), 32'h0);
    check_eq("clr_ch_kept", 32'(fault_ch), 32'd5);
    clr = 1'b0; req = 8'h00;

    // Reset mid-ACTIVE.
    do_reset();
    req = 8'h40;
    tick();
    fb = 8'h40;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_eq("rst_grant", 32'(grant), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0; fb = 8'h00; req = 8'hC0;
    tick();
    check_eq("rst_regrant", 32'(grant), 32'h40);

    // N=3 wrap.
    do_reset();
    tick();
    rst3 = 1'b0;
    serve3(3'b100, 3'b100, "n3_ch2");
    serve3(3'b101, 3'b001, "n3_wrap");
    req3 = 3'b111;
    tick();
    check_eq("n3_ptr1", 32'(grant3), 32'h2);

    // Randomised run.
    do_reset();
    frozen = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      if (c % 50 == 0) frozen = ($urandom_range(3) == 0) ? (8'(1) << $urandom_range(7)) : 8'h00;
      follow = 8'($urandom) & ~frozen;
      fb     = (fb & ~follow) | (grant & follow);
      if ($urandom_range(47) == 0) begin b = $urandom_range(7); fb[b] = 1'b1; end
      if ($urandom_range(99) == 0) fb = fb & frozen;
      if ($urandom_range(2) == 0) begin b = $urandom_range(7); req[b] = ~req[b]; end
      clr = ($urandom_range(7) == 0);
      rst = ($urandom_range(299) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
